// File: rtl/lsu_pkg.sv
// Shared types, Funct3 encodings and size/lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam int unsigned BE_WIDTH = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Undefined encodings fall through to word access.
    function automatic lsu_size_e f3_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    // Low address bits truncated to the access size.
    function automatic logic [1:0] eff_offset(input lsu_size_e size, input logic [1:0] offset);
        case (size)
            SZ_B:    return offset;
            SZ_H:    return {offset[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] offset);
        case (size)
            SZ_H:    return offset[0];
            SZ_W:    return |offset;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_WIDTH-1:0] store_be(input lsu_size_e size,
                                                     input logic [1:0] offset);
        case (size)
            SZ_B:    return 4'b0001 << offset;
            SZ_H:    return 4'b0011 << {offset[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension (purely combinational).
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            offset_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    lsu_size_e             size;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        size    = f3_size(funct3_i);
        shifted = rdata_i >> {eff_offset(size, offset_i), 3'b000};
        case (size)
            SZ_B: data_o = funct3_i[2] ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                       : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            SZ_H: data_o = funct3_i[2] ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                       : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: drives a req/gnt/rvalid data port, stalls while busy, aligns load data.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses pulse misalign instead of issuing.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BE_WIDTH-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  stall,
    output logic                  misalign
);

    lsu_state_e            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offset_q, offset_d;
    logic [DATA_WIDTH-1:0] load_data;
    lsu_size_e             req_size;
    logic                  trap;

    assign req_size = f3_size(Funct3);

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign trap     = is_misaligned(req_size, ALUResult[1:0]);
    assign misalign = misalign_q;
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata_i  (mem_rdata),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ex_valid && !MemRead && !MemWrite) begin
                    wb_data_d  = ALUResult;
                    wb_valid_d = 1'b1;
                end else if (ex_valid && trap) begin
`ifdef MISALIGN_TRAP_EN
                    misalign_d = 1'b1;
`endif
                end else if (ex_valid) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_addr_d  = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                    funct3_d    = Funct3;
                    offset_d    = ALUResult[1:0];
                    // Loads fetch the whole word; lane selection happens on return.
                    mem_be_d    = MemWrite ? store_be(req_size, ALUResult[1:0]) : 4'b1111;
                    if (!MemWrite) begin
                        mem_wdata_d = '0;
                    end else begin
                        case (req_size)
                            SZ_B:    mem_wdata_d = {4{WrData[7:0]}};
                            SZ_H:    mem_wdata_d = {2{WrData[15:0]}};
                            default: mem_wdata_d = WrData;
                        endcase
                    end
                end
            end
            REQ: begin
                mem_req_d = !mem_gnt;
                if (mem_gnt) begin
                    state_d = mem_we_q ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    wb_data_d  = load_data;
                    wb_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign ex_ready  = (state_q == IDLE);
    assign stall     = !ex_ready;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory reference model plus a random memory responder.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        ex_valid, ex_ready, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WrData;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, stall, misalign;
    logic [31:0] wb_data;

    load_store_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .ALUResult  (ALUResult),
        .WrData     (WrData),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .stall      (stall),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    int          errors = 0;
    int          checks = 0;
    mem_exp_t    wq[$];
    logic [31:0] wbq[$];
    int          exp_mis = 0;
    logic [7:0]  ref_mem [0:255];   // byte view of 0x100..0x1FF
    logic [31:0] resp_mem [0:63];   // word view used by the responder
    int          gnt_fix = -1;
    int          rd_fix  = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input bit push_wb);
        int          n = 0;
        int          s;
        bit          mis;
        logic [31:0] base, v;
        mem_exp_t    e;
        while (!ex_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ex_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ex_ready still %b after %0d cycles", ex_ready, n);
        end
        ex_valid  = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        ALUResult = a;
        WrData    = d;
        s    = acc_size(f3);
        base = a & ~32'(s - 1);
        mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (rd || wr) mis = ((a & 32'(s - 1)) != 0);
`endif
        if (!rd && !wr) begin
            wbq.push_back(a);
        end else if (mis) begin
            exp_mis++;
        end else if (wr) begin
            e.we    = 1'b1;
            e.addr  = {a[31:2], 2'b00};
            e.be    = 4'((1 << s) - 1) << base[1:0];
            e.wdata = (s == 1) ? {4{d[7:0]}} : (s == 2) ? {2{d[15:0]}} : d;
            wq.push_back(e);
            for (int i = 0; i < s; i++) ref_mem[8'(base + i)] = d[8*i +: 8];
        end else begin
            e.we    = 1'b0;
            e.addr  = {a[31:2], 2'b00};
            e.be    = 4'hf;
            e.wdata = '0;
            wq.push_back(e);
            v = '0;
            for (int i = 0; i < s; i++) v = v | (32'(ref_mem[8'(base + i)]) << (8 * i));
            if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
            if (push_wb) wbq.push_back(v);
        end
        @(posedge clk);
        #1;
        ex_valid  = 1'b0;
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        ALUResult = $urandom;
    endtask

    // Memory responder: random grant delay, random read latency, stray rvalid when idle.
    initial begin
        logic        req_s, we_s, hs;
        logic [31:0] addr_s, wd_s, rd_addr;
        logic [3:0]  be_s;
        bit          req_active, rd_pending;
        int          gnt_cnt, rd_cnt;
        req_active = 0;
        rd_pending = 0;
        gnt_cnt    = 0;
        rd_cnt     = 0;
        rd_addr    = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            req_s  = mem_req;
            we_s   = mem_we;
            addr_s = mem_addr;
            be_s   = mem_be;
            wd_s   = mem_wdata;
            @(posedge clk);
            #1;
            hs         = req_s && mem_gnt;
            mem_rvalid = 1'b0;
            if (hs) begin
                req_active = 0;
                if (we_s) begin
                    for (int b = 0; b < 4; b++)
                        if (be_s[b]) resp_mem[addr_s[7:2]][8*b +: 8] = wd_s[8*b +: 8];
                end else begin
                    rd_pending = 1;
                    rd_addr    = addr_s;
                    rd_cnt     = (rd_fix >= 0) ? rd_fix : int'($urandom_range(0, 3));
                end
            end
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = resp_mem[rd_addr[7:2]];
                    rd_pending = 0;
                end else begin
                    rd_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
            if (mem_req) begin
                if (!req_active) begin
                    req_active = 1;
                    gnt_cnt    = (gnt_fix >= 0) ? gnt_fix : int'($urandom_range(0, 2));
                end
                if (gnt_cnt == 0) begin
                    mem_gnt = 1'b1;
                end else begin
                    mem_gnt = 1'b0;
                    gnt_cnt--;
                end
            end else begin
                req_active = 0;
                mem_gnt    = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or a result.
    initial begin
        mem_exp_t    e;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (mem_req && mem_gnt) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got request addr %h, none expected", mem_addr);
                end else begin
                    e = wq.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_be", 32'(mem_be), 32'(e.be));
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (wb_valid) begin
                if (wbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb: got wb_data %h, none expected", wb_data);
                end else begin
                    w = wbq.pop_front();
                    chk("wb_data", wb_data, w);
                end
            end
            if (misalign) begin
                checks++;
                if (exp_mis == 0) begin
                    errors++;
                    $display("FAIL unexpected_misalign: got 1 expected 0");
                end else begin
                    exp_mis--;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ld_f3 [8];
        logic [2:0] st_f3 [4];
        logic [7:0] by;
        int         n, op;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011};
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 4; b++) begin
                by                     = 8'($urandom);
                ref_mem[w*4 + b]       = by;
                resp_mem[w][8*b +: 8]  = by;
            end
        end
        reset     = 1'b1;
        ex_valid  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        ALUResult = '0;
        WrData    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_ex_ready", 32'(ex_ready), 1);
        chk("rst_stall", 32'(stall), 0);
        @(posedge clk);
        #1;

        // SW granted on the first REQ cycle: exactly one request cycle.
        gnt_fix = 0;
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1);
        @(negedge clk);
        chk("t1_req", 32'(mem_req), 1);
        chk("t1_stall", 32'(stall), 1);
        @(negedge clk);
        chk("t1_req_done", 32'(mem_req), 0);
        chk("t1_ready", 32'(ex_ready), 1);
        @(posedge clk);
        #1;
        gnt_fix = -1;

        // Load extension cases on a known word.
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h80FF1234, 1);
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1);
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1);
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1);

        // Sub-word stores, then read back the whole word.
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1);
        issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000005A, 1);
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1);

        // Grant withheld for three cycles: request and stall held stable.
        gnt_fix = 3;
        issue(1'b0, 1'b1, 3'b010, 32'h104, 32'h12345678, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_req_held", 32'(mem_req), 1);
            chk("t4_stall", 32'(stall), 1);
            chk("t4_ex_ready", 32'(ex_ready), 0);
            chk("t4_addr", mem_addr, 32'h104);
            chk("t4_be", 32'(mem_be), 32'hf);
        end
        @(posedge clk);
        #1;
        gnt_fix = -1;
        issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1);

        // Non-memory op: result passes through one cycle later, no request.
        issue(1'b0, 1'b0, 3'b010, 32'h0000002A, 32'h0, 1);
        @(negedge clk);
        chk("t5_wb_valid", 32'(wb_valid), 1);
        chk("t5_wb_data", wb_data, 32'h2A);
        chk("t5_no_req", 32'(mem_req), 0);
        @(negedge clk);
        chk("t5_pulse_end", 32'(wb_valid), 0);
        @(posedge clk);
        #1;

        // Reset while waiting for read data; the late rvalid must be dropped.
        gnt_fix = 0;
        rd_fix  = 3;
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_req_low", 32'(mem_req), 0);
        chk("t6_ready", 32'(ex_ready), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_wb", 32'(wb_valid), 0);
        end
        @(posedge clk);
        #1;
        gnt_fix = -1;
        rd_fix  = -1;

`ifdef MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1);
        @(negedge clk);
        chk("t6_misalign", 32'(misalign), 1);
        chk("t6_mis_no_req", 32'(mem_req), 0);
        chk("t6_mis_ready", 32'(ex_ready), 1);
        @(posedge clk);
        #1;
`endif

        // Randomized mix of ALU ops, loads and stores.
        repeat (200) begin
            op = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            case (op)
                0: issue(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 1);
                1: issue(1'b1, 1'b0, ld_f3[$urandom_range(0, 7)],
                         32'h100 + $urandom_range(0, 63), $urandom, 1);
                default: issue($urandom_range(0, 1) == 1, 1'b1, st_f3[$urandom_range(0, 3)],
                               32'h100 + $urandom_range(0, 63), $urandom, 1);
            endcase
        end

        n = 0;
        while ((wq.size() != 0 || wbq.size() != 0 || exp_mis != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("drain_mem_queue", 32'(wq.size()), 0);
        chk("drain_wb_queue", 32'(wbq.size()), 0);
        chk("drain_misalign", 32'(exp_mis), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
